bemf_sched: RTL and testbench

Back-EMF measurement scheduler for the four motor axes. It periodically takes each enabled axis out of drive, lets the winding settle in coast, requests one conversion from the shared ADC serial engine, then restores drive before moving to the next axis. Its AxisActive/AxisMeasure outputs feed the per-axis motor output logic, and its results feed the BEMF register file and its interrupt bit.

---
 rtl/bemf_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_bemf_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bemf_sched.sv
// bemf_sched - back-EMF measurement scheduler for four motor axes.
//
// Once per period the block walks the enabled axes from lowest to highest.
// For each axis it forces the winding into coast, waits for it to settle,
// asks the shared ADC engine for one conversion, and then hands the axis back
// to PWM drive before moving on to the next axis.
//
// Ports:
//   clk, reset_n   single clock; synchronous active-low reset
//   axis_enable    per-axis enable, latched into the round mask at the tick
//   period_ticks   round period minus one, in clk cycles
//   settle_ticks   coast settle time; coast lasts settle_ticks+1 cycles
//   adc_ack        conversion complete (only honoured while adc_req=1)
//   adc_data       conversion result, valid with adc_ack
//   axis_active    1 = axis driven by PWM, 0 = forced coast
//   axis_measure   1 while that axis's conversion is requested
//   adc_req        conversion request level
//   adc_chan       axis being converted, stable while adc_req=1
//   result_valid   one-cycle strobe for result_data/result_axis/result_err
//   result_data    captured sample (0 after a timeout), held between strobes
//   result_axis    axis of the current result, held between strobes
//   result_err     1 = conversion timed out, held between strobes
//   round_done     one-cycle strobe with the result of the last axis
//   overrun        one-cycle strobe when a tick arrives while busy
//   busy           round in progress
//   dbg_state      current scheduler state (IDLE/SETTLE/CONVERT/RESTORE)
//
// ADC handshake: adc_req is a level that rises when the scheduler enters
// CONVERT and stays high, with adc_chan stable, until the cycle in which
// adc_ack=1 is sampled or the timeout expires; the transfer completes on the
// first clock edge where adc_req=1 and adc_ack=1. adc_ack seen while adc_req=0
// is ignored.
//
// Every output is a flop: the next-state logic also computes the next value
// of each output, so outputs line up with the state they describe.

module bemf_sched #(
    parameter int AdcBits       = 10,
    parameter int TimeoutCycles = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         axis_enable,
    input  logic [15:0]        period_ticks,
    input  logic [11:0]        settle_ticks,
    input  logic               adc_ack,
    input  logic [AdcBits-1:0] adc_data,
    output logic [3:0]         axis_active,
    output logic [3:0]         axis_measure,
    output logic               adc_req,
    output logic [1:0]         adc_chan,
    output logic               result_valid,
    output logic [AdcBits-1:0] result_data,
    output logic [1:0]         result_axis,
    output logic               result_err,
    output logic               round_done,
    output logic               overrun,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        RESTORE = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [1:0]    axis, axis_next;
    logic [3:0]    mask, mask_next;
    logic [11:0]   settle_cnt, settle_next;
    logic [TW-1:0] tmo_cnt, tmo_next;
    logic [15:0]   count, count_next;
    logic          tick, tick_next;

    logic [AdcBits-1:0] data_next;
    logic [1:0]         raxis_next;
    logic               err_next, rvalid_next, rdone_next;

    logic [3:0] active_d, measure_d;
    logic       req_d, busy_d, overrun_d;
    logic [1:0] chan_d;

    logic [2:0] lowest, above;
    logic       start_ok;

    // Returns {found, index} of the lowest set bit of m at or above 'from'.
    function automatic logic [2:0] find_axis(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    // Period counter: tick in the cycle where count==period_ticks.
    // tick_next predicts the following cycle's tick so overrun can be a flop
    // that is high in the same cycle as the tick it reports.
    always_comb begin
        tick       = (count == period_ticks);
        count_next = tick ? 16'd0 : count + 16'd1;
        tick_next  = (count_next == period_ticks);
    end

    always_comb begin
        lowest   = find_axis(axis_enable, 3'd0);
        above    = find_axis(mask, {1'b0, axis} + 3'd1);
        start_ok = tick && lowest[2];
    end

    always_comb begin : next_state
        state_next  = state;
        axis_next   = axis;
        mask_next   = mask;
        settle_next = settle_cnt;
        tmo_next    = tmo_cnt;
        data_next   = result_data;
        raxis_next  = result_axis;
        err_next    = result_err;
        rvalid_next = 1'b0;
        rdone_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next  = SETTLE;
                    mask_next   = axis_enable;
                    axis_next   = lowest[1:0];
                    settle_next = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == settle_ticks) begin
                    state_next = CONVERT;
                    tmo_next   = '0;
                end else begin
                    settle_next = settle_cnt + 12'd1;
                end
            end
            CONVERT: begin
                // An ack in the final timeout cycle still counts as a good sample.
                if (adc_ack) begin
                    state_next  = RESTORE;
                    data_next   = adc_data;
                    err_next    = 1'b0;
                    raxis_next  = axis;
                    rvalid_next = 1'b1;
                    rdone_next  = !above[2];
                end else if (tmo_cnt == TW'(TimeoutCycles - 1)) begin
                    state_next  = RESTORE;
                    data_next   = '0;
                    err_next    = 1'b1;
                    raxis_next  = axis;
                    rvalid_next = 1'b1;
                    rdone_next  = !above[2];
                end else begin
                    tmo_next = tmo_cnt + TW'(1);
                end
            end
            RESTORE: begin
                if (above[2]) begin
                    state_next  = SETTLE;
                    axis_next   = above[1:0];
                    settle_next = '0;
                end else if (start_ok) begin
                    // The last RESTORE is already not busy, so a tick landing
                    // here starts the next round instead of being lost.
                    state_next  = SETTLE;
                    mask_next   = axis_enable;
                    axis_next   = lowest[1:0];
                    settle_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin : next_outputs
        active_d  = 4'hF;
        measure_d = 4'h0;
        req_d     = 1'b0;
        chan_d    = adc_chan;
        if ((state_next == SETTLE) || (state_next == CONVERT)) begin
            active_d[axis_next] = 1'b0;
        end
        if (state_next == CONVERT) begin
            measure_d[axis_next] = 1'b1;
            req_d                = 1'b1;
            chan_d               = axis_next;
        end
        // The RESTORE of the last axis already reports not busy.
        busy_d    = (state_next == SETTLE) || (state_next == CONVERT) ||
                    ((state_next == RESTORE) && !rdone_next);
        overrun_d = tick_next && busy_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            axis         <= 2'd0;
            mask         <= 4'h0;
            settle_cnt   <= '0;
            tmo_cnt      <= '0;
            count        <= 16'd0;
            axis_active  <= 4'hF;
            axis_measure <= 4'h0;
            adc_req      <= 1'b0;
            adc_chan     <= 2'd0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_axis  <= 2'd0;
            result_err   <= 1'b0;
            round_done   <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            axis         <= axis_next;
            mask         <= mask_next;
            settle_cnt   <= settle_next;
            tmo_cnt      <= tmo_next;
            count        <= count_next;
            axis_active  <= active_d;
            axis_measure <= measure_d;
            adc_req      <= req_d;
            adc_chan     <= chan_d;
            result_valid <= rvalid_next;
            result_data  <= data_next;
            result_axis  <= raxis_next;
            result_err   <= err_next;
            round_done   <= rdone_next;
            overrun      <= overrun_d;
            busy         <= busy_d;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_bemf_sched.sv
// tb_bemf_sched - directed bench for bemf_sched.
// Expected results {round_done, err, axis, data} are queued when a scenario
// is set up; a negedge monitor pops and compares on every result_valid and
// also collects coast/request lengths, strobe counts and invariant breaks.

module tb_bemf_sched;

    localparam int W = 14;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  axis_enable;
    logic [15:0] period_ticks;
    logic [11:0] settle_ticks;
    logic        adc_ack;
    logic [9:0]  adc_data;
    logic [3:0]  axis_active;
    logic [3:0]  axis_measure;
    logic        adc_req;
    logic [1:0]  adc_chan;
    logic        result_valid;
    logic [9:0]  result_data;
    logic [1:0]  result_axis;
    logic        result_err;
    logic        round_done;
    logic        overrun;
    logic        busy;
    logic [1:0]  dbg_state;

    bemf_sched #(.AdcBits(10), .TimeoutCycles(256)) dut (
        .clk(clk), .reset_n(reset_n), .axis_enable(axis_enable),
        .period_ticks(period_ticks), .settle_ticks(settle_ticks),
        .adc_ack(adc_ack), .adc_data(adc_data),
        .axis_active(axis_active), .axis_measure(axis_measure),
        .adc_req(adc_req), .adc_chan(adc_chan),
        .result_valid(result_valid), .result_data(result_data),
        .result_axis(result_axis), .result_err(result_err),
        .round_done(round_done), .overrun(overrun), .busy(busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0, n_fails = 0;
    int sb_checks = 0, sb_fails = 0;

    // ---------------- ADC responder ----------------
    logic [9:0] ack_tab [4] = '{10'h155, 10'h0AA, 10'h2C3, 10'h001};
    logic resp_on = 1'b0;
    logic manual_ack = 1'b0;
    int   ack_delay = 5;
    int   hi = 0;

    always @(negedge clk) begin
        if (!reset_n || !resp_on) begin
            hi       = 0;
            adc_ack  = manual_ack;
            adc_data = manual_ack ? 10'h3C3 : 10'h000;
        end else if (adc_req) begin
            hi++;
            adc_ack  = (hi == ack_delay);
            adc_data = ack_tab[adc_chan];
        end else begin
            hi       = 0;
            adc_ack  = 1'b0;
            adc_data = 10'h000;
        end
    end

    // ---------------- monitor ----------------
    logic stat_clr = 1'b0;
    int   overrun_cnt = 0, rdone_cnt = 0, req_rise = 0, viol = 0;
    int   coast_run = 0, req_run = 0;
    logic [3:0] touched = 4'h0;
    logic prev_req = 1'b0;
    int   coast_q[$];
    int   req_q[$];

    always @(negedge clk) begin : monitor
        logic [W-1:0] got, expv;
        if (!reset_n) begin
            prev_req  = 1'b0;
            coast_run = 0;
            req_run   = 0;
        end else begin
            if (stat_clr) begin
                overrun_cnt = 0; rdone_cnt = 0; req_rise = 0; viol = 0;
                coast_run = 0; req_run = 0; touched = 4'h0;
                coast_q.delete(); req_q.delete();
            end
            if (result_valid) begin
                got = {round_done, result_err, result_axis, result_data};
                sb_checks++;
                if (exp_q.size() == 0) begin
                    sb_fails++;
                    $display("FAIL result_unexpected got=%h exp=none", got);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin
                        sb_fails++;
                        $display("FAIL result got=%h exp=%h", got, expv);
                    end
                end
            end else if (round_done) begin
                sb_checks++;
                sb_fails++;
                $display("FAIL round_done_stray got=1 exp=0");
            end
            if (overrun) overrun_cnt++;
            if (round_done) rdone_cnt++;
            touched = touched | ~axis_active;
            if ($countones(~axis_active) > 1) viol++;
            if (!busy && axis_active != 4'hF) viol++;
            if (adc_req && axis_measure != (4'b0001 << adc_chan)) viol++;
            if (!adc_req && axis_measure != 4'h0) viol++;
            if (axis_active == 4'hF) coast_run = 0;
            else if (!adc_req) coast_run++;
            if (adc_req && !prev_req) begin
                coast_q.push_back(coast_run);
                req_rise++;
            end
            if (adc_req) req_run++;
            else if (prev_req) begin
                req_q.push_back(req_run);
                req_run = 0;
            end
            prev_req = adc_req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", name, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
    endtask

    task automatic wait_rdone(input int target, input int budget, input string name);
        int n = 0;
        while (rdone_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        chk(name, rdone_cnt, target);
    endtask

    task automatic wait_req(input int budget, input string name);
        int n = 0;
        while (!adc_req && n < budget) begin
            step(1);
            n++;
        end
        chk(name, {31'b0, adc_req}, 1);
    endtask

    task automatic chk_lens(input string name, input int n, input int coast, input int req);
        chk({name, "_coast_n"}, coast_q.size(), n);
        chk({name, "_req_n"}, req_q.size(), n);
        foreach (coast_q[i]) chk({name, "_coast_len"}, coast_q[i], coast);
        foreach (req_q[i]) chk({name, "_req_len"}, req_q[i], req);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n      = 1'b0;
        axis_enable  = 4'h0;
        period_ticks = 16'd199;
        settle_ticks = 12'd3;
        step(3);

        // reset values
        chk("rst_active", {28'b0, axis_active}, 32'hF);
        chk("rst_measure", {28'b0, axis_measure}, 0);
        chk("rst_req", {31'b0, adc_req}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rvalid", {31'b0, result_valid}, 0);
        chk("rst_rdata", {22'b0, result_data}, 0);
        chk("rst_strobes", {30'b0, round_done, overrun}, 0);
        chk("rst_state", {30'b0, dbg_state}, 0);
        reset_n = 1'b1;

        // single round on axes 0 and 2
        do_reset();
        clear_stats();
        resp_on     = 1'b1;
        axis_enable = 4'b0101;
        exp_q.push_back({1'b0, 1'b0, 2'd0, 10'h155});
        exp_q.push_back({1'b1, 1'b0, 2'd2, 10'h2C3});
        wait_rdone(1, 400, "s1_round_done");
        axis_enable = 4'h0;
        step(2);
        chk_lens("s1", 2, 4, 5);
        chk("s1_touched", {28'b0, touched}, 32'h5);
        chk("s1_viol", viol, 0);
        chk("s1_overrun", overrun_cnt, 0);

        // timeout on axis 3
        period_ticks = 16'd999;
        do_reset();
        clear_stats();
        resp_on     = 1'b0;
        axis_enable = 4'b1000;
        exp_q.push_back({1'b1, 1'b1, 2'd3, 10'h000});
        wait_rdone(1, 1500, "s2_round_done");
        axis_enable = 4'h0;
        step(3);
        chk_lens("s2", 1, 4, 256);
        chk("s2_hold_err", {31'b0, result_err}, 1);
        chk("s2_hold_axis", {30'b0, result_axis}, 3);
        chk("s2_touched", {28'b0, touched}, 32'h8);
        chk("s2_viol", viol, 0);

        // overrun: ticks every 21 cycles, round lasts 148
        period_ticks = 16'd20;
        settle_ticks = 12'd30;
        do_reset();
        clear_stats();
        resp_on     = 1'b1;
        axis_enable = 4'hF;
        exp_q.push_back({1'b0, 1'b0, 2'd0, 10'h155});
        exp_q.push_back({1'b0, 1'b0, 2'd1, 10'h0AA});
        exp_q.push_back({1'b0, 1'b0, 2'd2, 10'h2C3});
        exp_q.push_back({1'b1, 1'b0, 2'd3, 10'h001});
        wait_rdone(1, 400, "s3_round_done");
        axis_enable = 4'h0;
        step(30);
        chk("s3_overrun", overrun_cnt, 7);
        chk("s3_rdone", rdone_cnt, 1);
        chk_lens("s3", 4, 31, 5);
        chk("s3_viol", viol, 0);

        // mask change during the axis-0 conversion
        period_ticks = 16'd199;
        settle_ticks = 12'd3;
        do_reset();
        clear_stats();
        resp_on     = 1'b1;
        axis_enable = 4'hF;
        exp_q.push_back({1'b0, 1'b0, 2'd0, 10'h155});
        exp_q.push_back({1'b0, 1'b0, 2'd1, 10'h0AA});
        exp_q.push_back({1'b0, 1'b0, 2'd2, 10'h2C3});
        exp_q.push_back({1'b1, 1'b0, 2'd3, 10'h001});
        exp_q.push_back({1'b1, 1'b0, 2'd0, 10'h155});
        wait_req(300, "s4_req");
        axis_enable = 4'h1;
        wait_rdone(2, 700, "s4_round_done");
        axis_enable = 4'h0;
        step(2);
        chk("s4_req_rise", req_rise, 5);
        chk("s4_touched", {28'b0, touched}, 32'hF);
        chk("s4_viol", viol, 0);

        // reset while converting, then a late ack
        do_reset();
        clear_stats();
        resp_on     = 1'b0;
        axis_enable = 4'h1;
        wait_req(300, "s5_req");
        step(2);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("s5_active", {28'b0, axis_active}, 32'hF);
        chk("s5_req", {31'b0, adc_req}, 0);
        chk("s5_busy", {31'b0, busy}, 0);
        chk("s5_state", {30'b0, dbg_state}, 0);
        manual_ack = 1'b1;
        step(1);
        manual_ack = 1'b0;
        step(3);
        chk("s5_no_rvalid", {31'b0, result_valid}, 0);
        chk("s5_still_idle", {30'b0, dbg_state}, 0);
        clear_stats();
        resp_on = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 2'd0, 10'h155});
        wait_rdone(1, 400, "s5_round_done");
        axis_enable = 4'h0;
        step(2);
        chk_lens("s5", 1, 4, 5);

        // zero mask across three ticks
        period_ticks = 16'd9;
        do_reset();
        clear_stats();
        axis_enable = 4'h0;
        step(35);
        chk("s6_req_rise", req_rise, 0);
        chk("s6_rdone", rdone_cnt, 0);
        chk("s6_overrun", overrun_cnt, 0);
        chk("s6_touched", {28'b0, touched}, 0);
        chk("s6_viol", viol, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        n_checks += sb_checks;
        n_fails  += sb_fails;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
